// File: rtl/generation_scheduler.sv
// generation_scheduler
//   Drives the lumber-field automaton to an arbitrary target generation without
//   stepping it target times. It steps the field one generation per STEP/CHECK
//   pair and runs Brent's cycle search against a snapshot (tortoise) of the
//   field state. Once a repeat is found it reduces the outstanding distance
//   modulo the period with a bit-serial restoring divider, then steps only the
//   residual generations. This block is the field's only source of enable.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start, target   one-cycle run request and the generation to reach;
//                   accepted only in IDLE/DONE
//   trees,
//   lumberyards     current field bitmaps (valid the cycle after field_en)
//   field_en        advance the field by one generation this cycle
//   busy, done      run in progress / target reached (held until next start)
//   gen             generation the field currently represents
//   period,
//   period_found    detected cycle length and its valid flag for this run
module generation_scheduler #(
  parameter int CELLS = 2500,
  parameter int GEN_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [GEN_W-1:0] target,
  input  logic [CELLS-1:0] trees,
  input  logic [CELLS-1:0] lumberyards,
  output logic             field_en,
  output logic             busy,
  output logic             done,
  output logic [GEN_W-1:0] gen,
  output logic [GEN_W-1:0] period,
  output logic             period_found
);

  localparam int CW = $clog2(GEN_W + 1);

  typedef enum logic [2:0] {IDLE, STEP, CHECK, MOD, RUN, DONE} state_t;

  state_t             state, state_nx;
  logic [GEN_W-1:0]   tgt, power, lam, rem;
  logic [2*CELLS-1:0] tortoise, cur;
  logic [GEN_W-1:0]   acc;     // running remainder of the divider
  logic [CW-1:0]      bitcnt;  // quotient bit being resolved
  logic               match, div_last;

  // divider datapath: shift in the next dividend bit, subtract period if it fits.
  // acc < period always holds, so acc_sh < 2*period and the borrow bit alone
  // decides whether the subtraction is taken.
  logic [GEN_W:0]     acc_sh, acc_sub;
  logic [GEN_W-1:0]   acc_nx;

  assign cur      = {trees, lumberyards};
  assign match    = (cur == tortoise);
  assign div_last = (bitcnt == CW'(GEN_W - 1));
  assign acc_sh   = {acc, rem[GEN_W-1]};
  assign acc_sub  = acc_sh - {1'b0, period};
  assign acc_nx   = acc_sub[GEN_W] ? acc_sh[GEN_W-1:0] : acc_sub[GEN_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    field_en = 1'b0;
    case (state)
      IDLE, DONE: if (start) state_nx = (target == '0) ? DONE : STEP;
      STEP: begin
        field_en = 1'b1;
        state_nx = CHECK;
      end
      CHECK: begin
        // reaching the target wins even if the states also match
        if (gen == tgt)  state_nx = DONE;
        else if (match)  state_nx = MOD;
        else             state_nx = STEP;
      end
      MOD: if (div_last) state_nx = (acc_nx == '0) ? DONE : RUN;
      RUN: begin
        field_en = 1'b1;
        if (rem == GEN_W'(1)) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      tgt          <= '0;
      power        <= '0;
      lam          <= '0;
      rem          <= '0;
      gen          <= '0;
      period       <= '0;
      period_found <= 1'b0;
      tortoise     <= '0;
      acc          <= '0;
      bitcnt       <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          // whatever the field holds now is generation 0 of the new run
          tgt          <= target;
          tortoise     <= cur;
          gen          <= '0;
          power        <= GEN_W'(1);
          lam          <= '0;
          period       <= '0;
          period_found <= 1'b0;
        end
        STEP: begin
          gen <= gen + GEN_W'(1);
          lam <= lam + GEN_W'(1);
        end
        CHECK: if (gen != tgt) begin
          if (match) begin
            period       <= lam;
            period_found <= 1'b1;
            rem          <= tgt - gen;
            acc          <= '0;
            bitcnt       <= '0;
          end else if (lam == power) begin
            // Brent: move the tortoise up to the hare and double the window
            tortoise <= cur;
            power    <= {power[GEN_W-2:0], 1'b0};
            lam      <= '0;
          end
        end
        MOD: begin
          acc    <= acc_nx;
          rem    <= {rem[GEN_W-2:0], 1'b0};
          bitcnt <= bitcnt + CW'(1);
          if (div_last) begin
            // skipping whole periods lands on an equivalent state
            rem <= acc_nx;
            gen <= tgt - acc_nx;
          end
        end
        RUN: begin
          rem <= rem - GEN_W'(1);
          gen <= gen + GEN_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_generation_scheduler.sv
// Bench for generation_scheduler with a 4-cell stub field: states 0..2 are a
// transient, 3..7 form a cycle of length 5. A small reference model predicts
// each run's outcome (detection point, period, residual steps, final stub
// state, enable-pulse count, latency); predictions go through a scoreboard
// queue and are checked when done rises.
module tb_generation_scheduler;
  localparam int CELLS = 4;
  localparam int GEN_W = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [GEN_W-1:0] target = '0;
  logic [CELLS-1:0] trees, lumberyards;
  logic             field_en, busy, done, period_found;
  logic [GEN_W-1:0] gen, period;

  generation_scheduler #(.CELLS(CELLS), .GEN_W(GEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .target(target),
    .trees(trees), .lumberyards(lumberyards), .field_en(field_en),
    .busy(busy), .done(done), .gen(gen), .period(period),
    .period_found(period_found)
  );

  always #5 clk = ~clk;

  // stub field
  logic [2:0]  sidx = 3'd0;
  logic        stub_clr = 1'b0;
  int unsigned en_total = 0;

  always @(posedge clk) begin
    if (stub_clr)      sidx <= 3'd0;
    else if (field_en) sidx <= (sidx == 3'd7) ? 3'd3 : sidx + 3'd1;
    if (field_en) en_total <= en_total + 1;
  end

  assign trees       = {1'b0, sidx} ^ 4'h5;
  assign lumberyards = {sidx, 1'b1};

  typedef struct {
    longint gen, period, pf, idx, pulses, lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int nxt(input int s);
    return (s == 7) ? 3 : s + 1;
  endfunction

  // stub state reached after n generations from s
  function automatic int adv(input int s, input longint n);
    int     c = s;
    longint m = n;
    while (c < 3 && m > 0) begin c++; m--; end
    if (c < 3) return c;
    return 3 + int'((longint'(c - 3) + m) % 5);
  endfunction

  task automatic model(input int s, input longint tgt, output exp_t e);
    int     tort = s, hare = s;
    longint pw = 1, lm = 0, g = 0, per = 0, r = 0;
    bit     found = 0, stop = (tgt == 0);
    while (!stop && g < 100000) begin
      hare = nxt(hare); g++; lm++;
      if (g == tgt) stop = 1;
      else if (hare == tort) begin found = 1; per = lm; stop = 1; end
      else if (lm == pw) begin tort = hare; pw = pw * 2; lm = 0; end
    end
    if (found) r = (tgt - g) % per;
    e.gen    = tgt;
    e.period = per;
    e.pf     = found;
    e.idx    = adv(s, tgt);
    e.pulses = g + r;
    e.lat    = 1 + 2 * g + (found ? GEN_W : 0) + r;
  endtask

  task automatic clr_stub();
    @(negedge clk); stub_clr = 1'b1;
    @(negedge clk); stub_clr = 1'b0;
  endtask

  // poke: pulse start with a different target while busy; it must be ignored
  task automatic run(input string tag, input longint tgt, input bit poke);
    exp_t        e, o;
    int          lat;
    int unsigned en0;
    model(int'(sidx), tgt, e);
    sb.push_back(e);
    @(negedge clk);
    start  = 1'b1;
    target = GEN_W'(tgt);
    en0    = en_total;
    @(negedge clk);
    start  = 1'b0;
    target = '1;
    lat    = 1;
    if (tgt != 0) chk({tag, "_busy"}, longint'(busy), 1);
    while (!done && lat < 5000) begin
      if (poke && lat == 4) begin start = 1'b1; target = GEN_W'(3); end
      @(negedge clk);
      lat++;
      start = 1'b0;
    end
    chk({tag, "_done"}, longint'(done), 1);
    o = sb.pop_front();
    chk({tag, "_gen"},    longint'(gen), o.gen);
    chk({tag, "_period"}, longint'(period), o.period);
    chk({tag, "_pfound"}, longint'(period_found), o.pf);
    chk({tag, "_field"},  longint'(sidx), o.idx);
    chk({tag, "_pulses"}, longint'(en_total - en0), o.pulses);
    chk({tag, "_lat"},    longint'(lat), o.lat);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_en"},     longint'(field_en), 0);
    chk({tag, "_busy"},   longint'(busy), 0);
    chk({tag, "_done"},   longint'(done), 0);
    chk({tag, "_gen"},    longint'(gen), 0);
    chk({tag, "_period"}, longint'(period), 0);
    chk({tag, "_pfound"}, longint'(period_found), 0);
  endtask

  initial begin
    bit prev_en, seen;
    int k;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;

    run("t1_big", 64'd1000000000, 0);
    run("t2_zero", 0, 0);
    clr_stub();
    run("t3_two", 2, 0);
    clr_stub();
    run("t4_eight", 8, 0);

    // reset while in RUN: two back-to-back enables only happen in RUN
    @(negedge clk);
    start  = 1'b1;
    target = GEN_W'(100);
    @(negedge clk);
    start   = 1'b0;
    prev_en = 1'b0;
    seen    = 1'b0;
    k       = 0;
    while (!seen && k < 500) begin
      if (field_en && prev_en) seen = 1'b1;
      else begin
        prev_en = field_en;
        @(negedge clk);
        k++;
      end
    end
    chk("t5_run_seen", longint'(seen), 1);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("t5_rst");
    reset = 1'b0;
    run("t5_restart", 10, 1);

    clr_stub();
    run("t7_rem1", 13, 0);
    clr_stub();
    run("t8_rem0", 17, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
